// File: rtl/mem_if_pkg.sv
// mem_if_pkg: shared state/error encodings and segment boundaries for the
// memory-stage initiator and the segmented memory model.
package mem_if_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {
    ERR_OK      = 2'd0,
    ERR_WPROT   = 2'd1,
    ERR_RANGE   = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_t;
  localparam int unsigned SEG_INSTR_LIMIT = 512;
  localparam int unsigned SEG_MEM_LIMIT   = 1024;
endpackage

// File: rtl/mem_seg_check.sv
// mem_seg_check: classifies an access against the segment map; range errors
// take priority over instruction-segment write protection.
module mem_seg_check
  import mem_if_pkg::*;
#(
  parameter int          ADDR_W      = 64,
  parameter int unsigned INSTR_LIMIT = SEG_INSTR_LIMIT,
  parameter int unsigned MEM_LIMIT   = SEG_MEM_LIMIT
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_write,
  output err_t              o_err
);
  assign o_err = (i_addr >= ADDR_W'(MEM_LIMIT))             ? ERR_RANGE :
                 (i_write && i_addr < ADDR_W'(INSTR_LIMIT)) ? ERR_WPROT : ERR_OK;
endmodule

// File: rtl/mem_access_initiator.sv
// mem_access_initiator: single-outstanding load/store requester for the
// segmented memory, with segment checks and a completion timeout.
module mem_access_initiator
  import mem_if_pkg::*;
#(
  parameter int          ADDR_W      = 64,
  parameter int          DATA_W      = 64,
  parameter int unsigned INSTR_LIMIT = SEG_INSTR_LIMIT,
  parameter int unsigned MEM_LIMIT   = SEG_MEM_LIMIT,
  parameter int          TIMEOUT     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] data_out,
  output logic              read,
  output logic              write,
  input  logic              valid
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  state_t            r_state, w_next;
  err_t              r_err, w_chk_err;
  logic              r_wr;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_rdata;
  logic              w_accept, w_done, w_timeout;
  mem_seg_check #(
    .ADDR_W(ADDR_W), .INSTR_LIMIT(INSTR_LIMIT), .MEM_LIMIT(MEM_LIMIT)
  ) u_seg (
    .i_addr(req_addr), .i_write(req_write), .o_err(w_chk_err)
  );
  assign w_accept  = (r_state == IDLE) && req_valid;
  assign w_done    = (r_state == ISSUE || r_state == WAIT) && valid;
  assign w_timeout = (r_state == WAIT) && !valid && (r_cnt == CNT_W'(TIMEOUT - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  // Strobes decode straight from the state so reset drops them without a clock.
  always_comb begin
    w_next    = r_state;
    req_ready = r_state == IDLE;
    rsp_valid = r_state == RESP;
    read      = (r_state == ISSUE) && !r_wr;
    write     = (r_state == ISSUE) && r_wr;
    case (r_state)
      IDLE:    w_next = req_valid ? ((w_chk_err == ERR_OK) ? ISSUE : RESP) : IDLE;
      ISSUE:   w_next = valid ? RESP : WAIT;
      WAIT:    w_next = (valid || w_timeout) ? RESP : WAIT;
      RESP:    w_next = rsp_ready ? IDLE : RESP;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_wr    <= 1'b0;
      r_err   <= ERR_OK;
      r_rdata <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_wr    <= req_write;
        r_err   <= w_chk_err;
        r_rdata <= '0;
      end
      if (w_done) begin
        r_rdata <= r_wr ? '0 : data_out;
        r_err   <= ERR_OK;
      end else if (w_timeout) r_err <= ERR_TIMEOUT;
      r_cnt <= (r_state == ISSUE) ? '0 : (r_state == WAIT) ? r_cnt + CNT_W'(1) : r_cnt;
    end
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign address   = r_addr;
  assign data_in   = r_wdata;
endmodule

// File: tb/tb_mem_access_initiator.sv
// tb_mem_access_initiator: directed requests with a response scoreboard;
// a negedge monitor pops expected responses as the pipeline accepts them.
module tb_mem_access_initiator;
  localparam int TIMEOUT = 16;
  logic        clk = 0, rst_n = 1;
  logic        req_valid = 0, req_ready, req_write = 0;
  logic [63:0] req_addr = 0, req_wdata = 0;
  logic        rsp_valid, rsp_ready = 1;
  logic [63:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic [63:0] address, data_in, data_out = 0;
  logic        read, write, valid = 0;
  int          n_cmp = 0, n_err = 0, rd_cyc = 0, wr_cyc = 0;
  logic [65:0] q[$];

  always #5 clk = ~clk;

  mem_access_initiator dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .address(address), .data_in(data_in), .data_out(data_out),
    .read(read), .write(write), .valid(valid)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [65:0] e;
    if (read)  rd_cyc++;
    if (write) wr_cyc++;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (q.size() == 0) check("unexpected_rsp", 64'(rsp_valid), 64'd0);
      else begin
        e = q.pop_front();
        check("rsp_rdata", rsp_rdata, e[65:2]);
        check("rsp_err", 64'(rsp_err), 64'(e[1:0]));
      end
    end
  end

  // lat: 0 = mem valid in the ISSUE cycle, n = valid in the n-th WAIT cycle, -1 = never
  task automatic do_req(input logic wr, input logic [63:0] addr, input logic [63:0] wdata,
                        input int lat, input logic [63:0] mem_data, input logic [63:0] exp_rd,
                        input logic [1:0] exp_err, input string name);
    int n = 0;
    int rd0 = rd_cyc;
    int wr0 = wr_cyc;
    bit mem_ok = (exp_err == 2'd0) || (exp_err == 2'd3);
    q.push_back({exp_rd, exp_err});
    req_valid = 1; req_write = wr; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 0;
    valid = (lat == 0);
    data_out = mem_data;
    if (mem_ok) begin
      @(negedge clk);
      check({name, "_read"}, 64'(read), 64'(!wr));
      check({name, "_write"}, 64'(write), 64'(wr));
      check({name, "_address"}, address, addr);
      check({name, "_data_in"}, data_in, wdata);
    end
    while (!rsp_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
      valid = (n == lat);
    end
    valid = 0;
    check({name, "_latency"}, 64'(n),
          64'((exp_err == 2'd0) ? lat + 1 : (exp_err == 2'd3) ? TIMEOUT + 1 : 0));
    check({name, "_read_cycles"}, 64'(rd_cyc - rd0), 64'(mem_ok && !wr));
    check({name, "_write_cycles"}, 64'(wr_cyc - wr0), 64'(mem_ok && wr));
  endtask

  task automatic drain();
    int n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_req_ready", 64'(req_ready), 64'd1);
  endtask

  initial begin
    #1 rst_n = 0;
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_rdata", rsp_rdata, 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    check("rst_address", address, 64'd0);
    check("rst_data_in", data_in, 64'd0);
    check("rst_read", 64'(read), 64'd0);
    check("rst_write", 64'(write), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    do_req(0, 64'd600, 64'd0, 0, 64'hDEADBEEF00000001, 64'hDEADBEEF00000001, 2'd0, "ld600"); drain();
    do_req(1, 64'd512, 64'h123456789ABCDEF0, 4, 64'hFFFF, 64'd0, 2'd0, "st512"); drain();
    do_req(1, 64'd10, 64'h55, 0, 64'd0, 64'd0, 2'd1, "st10"); drain();
    do_req(0, 64'd10, 64'd0, 2, 64'h1111, 64'h1111, 2'd0, "ld10"); drain();
    do_req(0, 64'd2048, 64'd0, 0, 64'd0, 64'd0, 2'd2, "ld2048"); drain();
    do_req(1, 64'd4096, 64'h9, 0, 64'd0, 64'd0, 2'd2, "st4096"); drain();
    do_req(0, 64'h0001_0000_0000_0010, 64'd0, 0, 64'd0, 64'd0, 2'd2, "ld_hi"); drain();
    do_req(1, 64'd511, 64'h7, 0, 64'd0, 64'd0, 2'd1, "st511"); drain();
    do_req(0, 64'd1023, 64'd0, 0, 64'h3FF, 64'h3FF, 2'd0, "ld1023"); drain();

    do_req(0, 64'd700, 64'd0, -1, 64'hBAD, 64'd0, 2'd3, "ld700_timeout");
    valid = 1; data_out = 64'hBAD;
    @(posedge clk); #1;
    @(negedge clk);
    check("late_valid_rsp_valid", 64'(rsp_valid), 64'd0);
    check("late_valid_req_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    valid = 0;
    do_req(0, 64'd600, 64'd0, 1, 64'hA5, 64'hA5, 2'd0, "ld600_after"); drain();

    rsp_ready = 0;
    do_req(0, 64'd800, 64'd0, 0, 64'h77, 64'h77, 2'd0, "bp800");
    repeat (5) begin
      @(negedge clk);
      check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      check("bp_rsp_rdata", rsp_rdata, 64'h77);
      check("bp_rsp_err", 64'(rsp_err), 64'd0);
      check("bp_req_ready", 64'(req_ready), 64'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1;
    drain();

    req_valid = 1; req_write = 0; req_addr = 64'd900; req_wdata = 64'h42;
    @(posedge clk); #1;
    req_valid = 0;
    check("rw_issue_read", 64'(read), 64'd1);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 0;
    #1;
    check("rw_req_ready", 64'(req_ready), 64'd1);
    check("rw_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rw_address", address, 64'd0);
    check("rw_data_in", data_in, 64'd0);
    check("rw_read", 64'(read), 64'd0);
    check("rw_write", 64'(write), 64'd0);
    check("rw_rsp_err", 64'(rsp_err), 64'd0);
    @(posedge clk); #1;
    rst_n = 1;
    repeat (3) begin
      @(negedge clk);
      check("rw_after_rsp_valid", 64'(rsp_valid), 64'd0);
    end
    check("rw_after_req_ready", 64'(req_ready), 64'd1);
    check("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end
endmodule
